// File: rtl/core_pkg.sv
// Shared core types: register-file defaults, register index type and the clear FSM states.
package core_pkg;
  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  typedef logic [$clog2(NREGS_D)-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback bundle of the register file: read ports, issue, writeback, clear and status.
interface regfile_bypass_sb_if import core_pkg::*; #(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D
);
  localparam int AW = $clog2(NREGS);

  logic            clear_req;
  logic            ready;
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] ReadData1, ReadData2;
  logic            busy1, busy2, stall;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            RegWrite;
  logic [AW-1:0]   WriteRegister;
  logic [XLEN-1:0] WriteData;

  modport master (
    output clear_req, rs1, rs2, issue_valid, issue_rd, RegWrite, WriteRegister, WriteData,
    input  ready, ReadData1, ReadData2, busy1, busy2, stall
  );
  modport slave (
    input  clear_req, rs1, rs2, issue_valid, issue_rd, RegWrite, WriteRegister, WriteData,
    output ready, ReadData1, ReadData2, busy1, busy2, stall
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits; a same-cycle issue beats a writeback to the same index.
module regfile_scoreboard import core_pkg::*; #(
  parameter  int NREGS = NREGS_D,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          hit1,
  input  logic          hit2,
  output logic          busy1,
  output logic          busy2
);
  logic [NREGS-1:0] sb, sb_nxt;

  always_comb begin
    sb_nxt = sb;
    if (clr_en) sb_nxt[clr_idx] = 1'b0;
    if (set_en) sb_nxt[set_idx] = 1'b1;
    sb_nxt[0] = 1'b0;
    if (flush) sb_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb <= '0;
    else       sb <= sb_nxt;
  end

  // a matching in-flight write resolves the hazard through the bypass
  assign busy1 = sb[rs1] & ~hit1;
  assign busy2 = sb[rs2] & ~hit2;
endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file with clear sequencer and RAW scoreboard.
// REGFILE_BYPASS_EN enables write-to-read bypass and the matching busy mask.
module regfile_bypass_sb import core_pkg::*; #(
  parameter  int XLEN  = XLEN_D,
  parameter  int NREGS = NREGS_D,
  localparam int AW    = $clog2(NREGS)
) (
  input logic                clk,
  input logic                reset,
  regfile_bypass_sb_if.slave bus
);
  localparam logic [AW-1:0] LAST = AW'(NREGS-1);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  rf_state_e       state;
  logic            ready_q;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREGS];
  logic            accept, wr_en, set_en, flush, hit1, hit2, busy1, busy2;

  // a clear request in READY swallows any write or issue of the same cycle
  assign accept = ready_q & ~bus.clear_req;
  assign wr_en  = accept & bus.RegWrite & (bus.WriteRegister != ZERO);
  assign set_en = accept & bus.issue_valid & (bus.issue_rd != ZERO);
  assign flush  = ~ready_q | bus.clear_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST) begin
            state   <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        READY: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            clr_idx <= AW'(1);
          end
        end
        default: begin
          state   <= CLEAR;
          ready_q <= 1'b0;
          clr_idx <= AW'(1);
        end
      endcase
    end
  end

  // storage is deliberately unreset; the sequencer zeroes it
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_idx] <= '0;
    else if (wr_en)     mem[bus.WriteRegister] <= bus.WriteData;
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = ready_q & bus.RegWrite & (bus.WriteRegister == bus.rs1) & (bus.rs1 != ZERO);
  assign hit2 = ready_q & bus.RegWrite & (bus.WriteRegister == bus.rs2) & (bus.rs2 != ZERO);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign bus.ReadData1 = (~ready_q | (bus.rs1 == ZERO)) ? '0 :
                         hit1 ? bus.WriteData : mem[bus.rs1];
  assign bus.ReadData2 = (~ready_q | (bus.rs2 == ZERO)) ? '0 :
                         hit2 ? bus.WriteData : mem[bus.rs2];

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .set_en  (set_en),
    .set_idx (bus.issue_rd),
    .clr_en  (wr_en),
    .clr_idx (bus.WriteRegister),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .hit1    (hit1),
    .hit2    (hit2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

  assign bus.ready = ready_q;
  assign bus.busy1 = busy1;
  assign bus.busy2 = busy2;
  assign bus.stall = ~ready_q | busy1 | busy2;
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor of the core's integer register file.
- Two combinational read ports and one synchronous write port, x0 hardwired to zero.
- A multi-cycle clear sequencer with a ready flag replaces the one-shot array reset.
- A per-register busy scoreboard reports read-after-write hazards to the decode/stall logic.
- Sits between decode (read and issue) and writeback (write).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; localparam derived from NREGS, not overridable.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  synchronous request to re-zero the file; honoured only in READY.
- ready  out  1  high when the file is usable (state READY).
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- ReadData1  out  XLEN  read data, port 1.
- ReadData2  out  XLEN  read data, port 2.
- busy1  out  1  rs1 has a pending, unresolved write.
- busy2  out  1  rs2 has a pending, unresolved write.
- stall  out  1  equals !ready | busy1 | busy2.
- issue_valid  in  1  an instruction that writes issue_rd is issued this cycle.
- issue_rd  in  AW  destination of the issued instruction.
- RegWrite  in  1  writeback enable.
- WriteRegister  in  AW  writeback address.
- WriteData  in  XLEN  writeback data.

Behaviour:
- Reset, asynchronous and active-high:
  - state goes to CLEAR, clr_idx to 1, ready to 0, scoreboard to all 0.
  - The storage array itself is not reset.
- FSM states are CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 to reg[clr_idx], then increments clr_idx.
  - When clr_idx == NREGS-1, that register is written and the next state is READY.
  - CLEAR lasts exactly NREGS-1 cycles after reset deasserts; ready rises on the following edge.
  - RegWrite, issue_valid and clear_req are ignored.
  - ReadData1 and ReadData2 = 0; busy1 and busy2 = 0; stall = 1.
  - Scoreboard is held at all 0.
- READY:
  - clear_req=1 moves to CLEAR with clr_idx=1 and scoreboard all 0 on the next edge.
  - A write or issue presented in that same cycle is dropped.
- Write:
  - Occurs on the rising edge when ready & RegWrite & (WriteRegister != 0).
  - WriteRegister = 0 is always a no-op.
- Read:
  - Combinational. rsN = 0 returns 0.
  - Otherwise returns reg[rsN], subject to bypass.
- Bypass: when ready & RegWrite & WriteRegister == rsN != 0, ReadDataN = WriteData in the same cycle.
- Scoreboard (NREGS bits, bit 0 constant 0):
  - Set: ready & issue_valid & issue_rd != 0 sets sb[issue_rd] on the next edge.
  - Clear: an accepted write clears sb[WriteRegister] on the next edge.
  - Simultaneous set and clear of the same index: set wins (newer producer).
  - Different indices update independently.
- busyN = sb[rsN] & !(ready & RegWrite & WriteRegister == rsN). The in-flight write resolves the hazard through bypass.
- Both read ports with the same address behave identically; no arbitration is needed.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read bypass is active as described above.
  - busyN is masked by a matching in-flight write.
- Undefined:
  - Reads always return stored array contents; the new value is visible from the cycle after the write.
  - busyN = sb[rsN], so busy stays high during the write cycle and drops one cycle later.
  - Scoreboard set/clear rules are unchanged.

Decomposition:
- Shared package core_pkg holds:
  - XLEN default
  - NREGS default
  - register-index type
  - REG_ZERO constant
  - FSM state enum {CLEAR, READY}
- One natural sub-module: regfile_scoreboard, holding the busy bits, set/clear priority and the busy-mask logic.
- Storage, the clear FSM and bypass stay in the top level.

Test Plan:
- Deassert reset, hold all inputs 0 → ready stays 0 for 31 cycles and rises on cycle 32; every rs1/rs2 then reads 0x00000000.
- In READY, write x5=0xDEADBEEF with rs1=5 in the same cycle:
  - With REGFILE_BYPASS_EN, ReadData1=0xDEADBEEF that cycle and busy1=0.
  - Without it, ReadData1=0 that cycle and 0xDEADBEEF the next.
- Write x0=0x12345678, then read rs2=0 → ReadData2=0.
- Issue rd=7, then read rs1=7 → busy1=1 and stall=1 until writeback of x7. Issue rd=7 and write x7 in the same cycle → busy1 stays 1.
- Write x3=0xA5A5A5A5, pulse clear_req:
  - ready drops for 31 cycles and the scoreboard clears.
  - x3 then reads 0; a RegWrite asserted during CLEAR has no effect.
- Assert reset mid-CLEAR (clr_idx=10) → ready=0 immediately; the sequence restarts from index 1 and completes 31 cycles after deassert.
